// File: rtl/wb_pkg.sv
// Shared constants and result record for the writeback arbiter.
// The optional same-cycle bypass is enabled by defining WB_BYPASS_EN.
package wb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_PHY_WIDTH  = 6;
    localparam int WB_ROB_WIDTH  = 5;
    localparam int WB_NUM_SRC    = 4;
    localparam int WB_NUM_WB     = 2;
    localparam int WB_QDEPTH     = 4;

    typedef struct packed {
        logic [WB_ROB_WIDTH-1:0]  rob_id;
        logic [WB_PHY_WIDTH-1:0]  rd_phy;
        logic                     rd_we;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_channel_fifo.sv
// Single-channel result FIFO: push at tail, pop at head, flush empties it.
// Head is read combinationally so the arbiter sees it in the same cycle.
module wb_channel_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [$clog2(DEPTH):0]   count,
    output logic [WIDTH-1:0]         head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [AW:0]      count_r;

    // Pointer and occupancy bookkeeping; a flush discards everything at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) wr_ptr_r <= wr_ptr_r + 1'b1;
            if (pop)  rd_ptr_r <= rd_ptr_r + 1'b1;
            case ({push, pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_r[wr_ptr_r] <= din;
    end

    assign count = count_r;
    assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/writeback_arbiter.sv
// Per-channel buffered writeback stage draining up to NUM_WB results per cycle
// with round-robin arbitration. Define WB_BYPASS_EN for 0-cycle empty-FIFO bypass.
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int PHY_WIDTH  = WB_PHY_WIDTH,
    parameter int ROB_WIDTH  = WB_ROB_WIDTH,
    parameter int NUM_SRC    = WB_NUM_SRC,
    parameter int NUM_WB     = WB_NUM_WB,
    parameter int QDEPTH     = WB_QDEPTH
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic [NUM_SRC-1:0]                     src_valid,
    output logic [NUM_SRC-1:0]                     src_ready,
    input  logic [NUM_SRC-1:0][ROB_WIDTH-1:0]      src_rob_id,
    input  logic [NUM_SRC-1:0][PHY_WIDTH-1:0]      src_rd_phy,
    input  logic [NUM_SRC-1:0]                     src_rd_we,
    input  logic [NUM_SRC-1:0][DATA_WIDTH-1:0]     src_data,
    output logic [NUM_WB-1:0]                      wb_valid,
    output logic [NUM_WB-1:0][ROB_WIDTH-1:0]       wb_rob_id,
    output logic [NUM_WB-1:0][PHY_WIDTH-1:0]       wb_rd_phy,
    output logic [NUM_WB-1:0]                      wb_rd_we,
    output logic [NUM_WB-1:0][DATA_WIDTH-1:0]      wb_data,
    output logic [NUM_WB-1:0][$clog2(NUM_SRC)-1:0] wb_src
);

    localparam int SRC_W   = $clog2(NUM_SRC);
    localparam int CNT_W   = $clog2(QDEPTH) + 1;
    localparam int ENTRY_W = ROB_WIDTH + PHY_WIDTH + 1 + DATA_WIDTH;

    logic [CNT_W-1:0]          count_s [NUM_SRC];
    logic [ENTRY_W-1:0]        head_s  [NUM_SRC];
    logic [ENTRY_W-1:0]        in_s    [NUM_SRC];
    logic [NUM_SRC-1:0]        empty_s, avail_s, push_s, pop_s, bypass_s;
    logic [NUM_WB-1:0][SRC_W:0] scan_s;
    logic [SRC_W-1:0]          rr_ptr_r, last_ch_s, sel_ch_s;
    logic [ENTRY_W-1:0]        sel_entry_s;
    logic                      any_grant_s;

    // Port k gets the k-th available channel scanning from start, wrapping.
    // Each result slot is {valid, channel}.
    function automatic logic [NUM_WB-1:0][SRC_W:0] rr_scan(
        input logic [NUM_SRC-1:0] avail,
        input logic [SRC_W-1:0]   start
    );
        logic [NUM_WB-1:0][SRC_W:0] res;
        logic [SRC_W-1:0]           ch;
        int                         found;
        res   = '0;
        found = 0;
        for (int j = 0; j < NUM_SRC; j++) begin
            ch = SRC_W'((int'(start) + j) % NUM_SRC);
            if (avail[ch]) begin
                for (int p = 0; p < NUM_WB; p++) begin
                    if (p == found) res[p] = {1'b1, ch};
                end
                found++;
            end
        end
        return res;
    endfunction

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_chan
        assign in_s[g]      = {src_rob_id[g], src_rd_phy[g], src_rd_we[g], src_data[g]};
        assign empty_s[g]   = (count_s[g] == '0);
        assign src_ready[g] = (count_s[g] < CNT_W'(QDEPTH));
        assign push_s[g]    = src_valid[g] && src_ready[g] && !flush && !bypass_s[g];

        wb_channel_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (QDEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .flush (flush),
            .push  (push_s[g]),
            .pop   (pop_s[g]),
            .din   (in_s[g]),
            .count (count_s[g]),
            .head  (head_s[g])
        );
    end

`ifdef WB_BYPASS_EN
    assign avail_s = ~empty_s | (src_valid & ~{NUM_SRC{flush}});
`else
    assign avail_s = ~empty_s;
`endif

    assign scan_s = rr_scan(avail_s, rr_ptr_r);

    // Drive writeback ports from the scan result and derive pops for the edge.
    always_comb begin
        wb_valid    = '0;
        wb_rob_id   = '0;
        wb_rd_phy   = '0;
        wb_rd_we    = '0;
        wb_data     = '0;
        wb_src      = '0;
        pop_s       = '0;
        bypass_s    = '0;
        any_grant_s = 1'b0;
        last_ch_s   = rr_ptr_r;
        sel_ch_s    = '0;
        sel_entry_s = '0;
        for (int p = 0; p < NUM_WB; p++) begin
            if (scan_s[p][SRC_W] && !flush && !rst) begin
                sel_ch_s = scan_s[p][SRC_W-1:0];
`ifdef WB_BYPASS_EN
                if (empty_s[sel_ch_s]) begin
                    sel_entry_s        = in_s[sel_ch_s];
                    bypass_s[sel_ch_s] = 1'b1;
                end else begin
                    sel_entry_s     = head_s[sel_ch_s];
                    pop_s[sel_ch_s] = 1'b1;
                end
`else
                sel_entry_s     = head_s[sel_ch_s];
                pop_s[sel_ch_s] = 1'b1;
`endif
                wb_valid[p] = 1'b1;
                {wb_rob_id[p], wb_rd_phy[p], wb_rd_we[p], wb_data[p]} = sel_entry_s;
                wb_src[p]   = sel_ch_s;
                any_grant_s = 1'b1;
                last_ch_s   = sel_ch_s;
            end else begin
                wb_valid[p] = 1'b0;
            end
        end
    end

    // Round-robin pointer moves just past the last channel granted this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= '0;
        end else if (flush) begin
            rr_ptr_r <= '0;
        end else if (any_grant_s) begin
            rr_ptr_r <= (last_ch_s == SRC_W'(NUM_SRC - 1)) ? '0 : last_ch_s + 1'b1;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter (default build, 4 channels, 2 ports):
// directed table, hand-written corner sequences and a random run against a queue model.
module tb_writeback_arbiter;
    import wb_pkg::*;

    logic                 clk;
    logic                 rst;
    logic                 flush;
    logic [3:0]           src_valid, src_ready, src_rd_we;
    logic [3:0][4:0]      src_rob_id;
    logic [3:0][5:0]      src_rd_phy;
    logic [3:0][31:0]     src_data;
    logic [1:0]           wb_valid, wb_rd_we;
    logic [1:0][4:0]      wb_rob_id;
    logic [1:0][5:0]      wb_rd_phy;
    logic [1:0][31:0]     wb_data;
    logic [1:0][1:0]      wb_src;

    writeback_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_rob_id (src_rob_id),
        .src_rd_phy (src_rd_phy),
        .src_rd_we  (src_rd_we),
        .src_data   (src_data),
        .wb_valid   (wb_valid),
        .wb_rob_id  (wb_rob_id),
        .wb_rd_phy  (wb_rd_phy),
        .wb_rd_we   (wb_rd_we),
        .wb_data    (wb_data),
        .wb_src     (wb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;

    // reference model: one queue of results per channel plus the scan start
    wb_entry_t mq [4][$];
    int        rr;

    // values sampled at the most recent negedge
    logic [3:0]       s_ready;
    logic [1:0]       s_wbv;
    logic [1:0][1:0]  s_src;
    logic [1:0][4:0]  s_rob;
    logic [1:0][5:0]  s_phy;
    logic [1:0][31:0] s_data;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] ready;
        logic [1:0] wbv;
        logic [1:0] src0;
        logic [1:0] src1;
    } vec_t;
    vec_t tbl [9];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        else
            pass_cnt++;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 4; c++) mq[c].delete();
        rr = 0;
    endtask

    task automatic rand_fields();
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r = $urandom;
            src_rob_id[i] = r[4:0];
            src_rd_phy[i] = r[10:5];
            src_rd_we[i]  = r[11];
            src_data[i]   = $urandom;
        end
    endtask

    // One clock: drive, check against model at negedge, advance model at posedge.
    task automatic step(input logic [3:0] v, input logic f);
        logic       ev [2];
        int         ech [2];
        int         k;
        logic [3:0] exp_ready, acc;
        wb_entry_t  e;
        src_valid = v;
        flush     = f;
        @(negedge clk);
        ev[0] = 1'b0; ev[1] = 1'b0; ech[0] = 0; ech[1] = 0; k = 0;
        if (!f) begin
            for (int j = 0; j < 4; j++) begin
                int c;
                c = (rr + j) % 4;
                if (mq[c].size() > 0 && k < 2) begin
                    ev[k] = 1'b1; ech[k] = c; k++;
                end
            end
        end
        for (int i = 0; i < 4; i++) exp_ready[i] = (mq[i].size() < 4);
        s_ready = src_ready; s_wbv = wb_valid; s_src = wb_src;
        s_rob = wb_rob_id; s_phy = wb_rd_phy; s_data = wb_data;
        check("src_ready", 64'(src_ready), 64'(exp_ready));
        check("wb_valid", 64'(wb_valid), 64'({ev[1], ev[0]}));
        for (int p = 0; p < 2; p++) begin
            if (ev[p]) begin
                e = mq[ech[p]][0];
                check("wb_src", 64'(wb_src[p]), 64'(ech[p]));
                check("wb_rob_id", 64'(wb_rob_id[p]), 64'(e.rob_id));
                check("wb_rd_phy", 64'(wb_rd_phy[p]), 64'(e.rd_phy));
                check("wb_rd_we", 64'(wb_rd_we[p]), 64'(e.rd_we));
                check("wb_data", 64'(wb_data[p]), 64'(e.data));
            end else begin
                check("idle_data", 64'({wb_rob_id[p], wb_rd_phy[p], wb_data[p]}), 64'd0);
            end
        end
        @(posedge clk);
        if (f) begin
            model_clear();
        end else begin
            for (int i = 0; i < 4; i++) acc[i] = v[i] && (mq[i].size() < 4);
            for (int p = 0; p < 2; p++) begin
                if (ev[p]) begin
                    mq[ech[p]].delete(0);
                    rr = (ech[p] + 1) % 4;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (acc[i]) begin
                    e.rob_id = src_rob_id[i];
                    e.rd_phy = src_rd_phy[i];
                    e.rd_we  = src_rd_we[i];
                    e.data   = src_data[i];
                    mq[i].push_back(e);
                end
            end
        end
        #1;
    endtask

    initial begin
        logic saw_full;
        int   r2;
        tbl[0] = '{4'b1111, 4'b1111, 2'b00, 2'd0, 2'd0};
        tbl[1] = '{4'b0000, 4'b1111, 2'b11, 2'd0, 2'd1};
        tbl[2] = '{4'b0000, 4'b1111, 2'b11, 2'd2, 2'd3};
        tbl[3] = '{4'b0000, 4'b1111, 2'b00, 2'd0, 2'd0};
        tbl[4] = '{4'b0100, 4'b1111, 2'b00, 2'd0, 2'd0};
        tbl[5] = '{4'b0000, 4'b1111, 2'b01, 2'd2, 2'd0};
        tbl[6] = '{4'b1001, 4'b1111, 2'b00, 2'd0, 2'd0};
        tbl[7] = '{4'b0000, 4'b1111, 2'b11, 2'd3, 2'd0};
        tbl[8] = '{4'b0000, 4'b1111, 2'b00, 2'd0, 2'd0};

        rst = 1'b1; flush = 1'b0; src_valid = 4'b0000;
        rand_fields();
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset then idle
        step(4'b0000, 1'b0);
        check("reset_ready", 64'(s_ready), 64'(4'b1111));
        check("reset_wbv", 64'(s_wbv), 64'(2'b00));

        // directed arbitration table
        for (int r = 0; r < 9; r++) begin
            rand_fields();
            step(tbl[r].valid, 1'b0);
            check("tbl_ready", 64'(s_ready), 64'(tbl[r].ready));
            check("tbl_wbv", 64'(s_wbv), 64'(tbl[r].wbv));
            if (tbl[r].wbv[0]) check("tbl_src0", 64'(s_src[0]), 64'(tbl[r].src0));
            if (tbl[r].wbv[1]) check("tbl_src1", 64'(s_src[1]), 64'(tbl[r].src1));
        end

        // single known result on channel 2
        rand_fields();
        src_rob_id[2] = 5'd5; src_rd_phy[2] = 6'd12; src_rd_we[2] = 1'b1; src_data[2] = 32'hDEAD_BEEF;
        step(4'b0100, 1'b0);
        check("ch2_push_wbv", 64'(s_wbv), 64'(2'b00));
        step(4'b0000, 1'b0);
        check("ch2_wbv", 64'(s_wbv), 64'(2'b01));
        check("ch2_src", 64'(s_src[0]), 64'd2);
        check("ch2_rob", 64'(s_rob[0]), 64'd5);
        check("ch2_phy", 64'(s_phy[0]), 64'd12);
        check("ch2_data", 64'(s_data[0]), 64'hDEAD_BEEF);
        step(4'b0000, 1'b0);
        check("ch2_after_wbv", 64'(s_wbv), 64'(2'b00));

        // saturate all channels so channel 1 backs up, then drain in order
        saw_full = 1'b0;
        for (int c = 0; c < 12; c++) begin
            rand_fields();
            step(4'b1111, 1'b0);
            if (!s_ready[1]) saw_full = 1'b1;
        end
        check("ch1_backpressure", 64'(saw_full), 64'd1);
        for (int c = 0; c < 14; c++) step(4'b0000, 1'b0);
        check("drained_ready", 64'(s_ready), 64'(4'b1111));
        check("drained_wbv", 64'(s_wbv), 64'(2'b00));

        // flush with a backlog and a same-cycle push on channel 3
        for (int c = 0; c < 4; c++) begin
            rand_fields();
            step(4'b1111, 1'b0);
        end
        rand_fields();
        step(4'b1000, 1'b1);
        check("flush_wbv", 64'(s_wbv), 64'(2'b00));
        step(4'b0000, 1'b0);
        check("post_flush_wbv", 64'(s_wbv), 64'(2'b00));
        check("post_flush_ready", 64'(s_ready), 64'(4'b1111));
        step(4'b0000, 1'b0);
        check("post_flush_wbv2", 64'(s_wbv), 64'(2'b00));

        // asynchronous reset mid-drain
        for (int c = 0; c < 4; c++) begin
            rand_fields();
            step(4'b1111, 1'b0);
        end
        step(4'b0000, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_rst_wbv", 64'(wb_valid), 64'(2'b00));
        check("async_rst_ready", 64'(src_ready), 64'(4'b1111));
        @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        step(4'b0000, 1'b0);
        check("after_rst_wbv", 64'(s_wbv), 64'(2'b00));
        step(4'b0000, 1'b0);
        check("after_rst_wbv2", 64'(s_wbv), 64'(2'b00));

        // random traffic against the queue model
        for (int c = 0; c < 400; c++) begin
            rand_fields();
            r2 = $urandom_range(0, 31);
            step(4'($urandom_range(0, 15)), (r2 == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
